// File: rtl/yuv2rgb_engine.sv
// Self-sequencing YUV444 -> RGB888 frame converter over a shared 16-bit word memory.
// Define YUV_FULL_RANGE_EN for full-range (JPEG) coefficients; limited-range BT.601 otherwise.
module yuv2rgb_engine #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned NUM_WORDS = 38400,
  parameter int unsigned Y_BASE    = 0,
  parameter int unsigned U_BASE    = 38400,
  parameter int unsigned V_BASE    = 76800,
  parameter int unsigned R_BASE    = 115200,
  parameter int unsigned G_BASE    = 153600,
  parameter int unsigned B_BASE    = 192000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              R_en,
  output logic [ADDR_W-1:0] R_addr,
  input  logic [15:0]       R_data,
  output logic              W_en,
  input  logic              W_ready,
  output logic [ADDR_W-1:0] W_addr,
  output logic [15:0]       W_data
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_Y, S_RD_U, S_RD_V, S_LAT_V, S_CALC, S_WR_R, S_WR_G, S_WR_B, S_FIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [15:0]       r_y, r_u, r_v;
  logic [15:0]       r_r_word, r_g_word, r_b_word;
  logic              r_busy, r_done, r_ren, r_wen;
  logic [ADDR_W-1:0] r_raddr, r_waddr;
  logic [15:0]       r_wdata;
  logic              w_busy_nxt, w_done_nxt, w_ren_nxt, w_wen_nxt;
  logic [ADDR_W-1:0] w_raddr_nxt, w_waddr_nxt;
  logic [15:0]       w_wdata_nxt;
  logic [23:0]       w_pix_even, w_pix_odd;
  logic [15:0]       w_r_word, w_g_word, w_b_word;

  // Scale-and-round result saturated to a byte.
  function automatic logic [7:0] clamp8(input logic signed [18:0] acc);
    logic signed [18:0] sh;
    sh = acc >>> 8;
    if (sh < 19'sd0)     return 8'd0;
    else if (|sh[18:8])  return 8'd255;
    else                 return sh[7:0];
  endfunction

  // One pixel conversion; returns {R, G, B}.
  function automatic logic [23:0] pixel(input logic [7:0] y, input logic [7:0] u,
                                        input logic [7:0] v);
    logic signed [18:0] c, d, e, acc_r, acc_g, acc_b;
    d = $signed({11'd0, u}) - 19'sd128;
    e = $signed({11'd0, v}) - 19'sd128;
`ifdef YUV_FULL_RANGE_EN
    c     = $signed({11'd0, y});
    acc_r = 19'sd256 * c + 19'sd359 * e + 19'sd128;
    acc_g = 19'sd256 * c - 19'sd88 * d - 19'sd183 * e + 19'sd128;
    acc_b = 19'sd256 * c + 19'sd454 * d + 19'sd128;
`else
    c     = $signed({11'd0, y}) - 19'sd16;
    acc_r = 19'sd298 * c + 19'sd409 * e + 19'sd128;
    acc_g = 19'sd298 * c - 19'sd100 * d - 19'sd208 * e + 19'sd128;
    acc_b = 19'sd298 * c + 19'sd516 * d + 19'sd128;
`endif
    return {clamp8(acc_r), clamp8(acc_g), clamp8(acc_b)};
  endfunction

  assign w_pix_even = pixel(r_y[7:0],  r_u[7:0],  r_v[7:0]);
  assign w_pix_odd  = pixel(r_y[15:8], r_u[15:8], r_v[15:8]);
  assign w_r_word   = {w_pix_odd[23:16], w_pix_even[23:16]};
  assign w_g_word   = {w_pix_odd[15:8],  w_pix_even[15:8]};
  assign w_b_word   = {w_pix_odd[7:0],   w_pix_even[7:0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_ren_nxt   = 1'b0;
    w_wen_nxt   = 1'b0;
    w_raddr_nxt = r_raddr;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;

    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RD_Y;
      S_RD_Y:  w_state_nxt = S_RD_U;
      S_RD_U:  w_state_nxt = S_RD_V;
      S_RD_V:  w_state_nxt = S_LAT_V;
      S_LAT_V: w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_WR_R;
      S_WR_R:  if (W_ready) w_state_nxt = S_WR_G;
      S_WR_G:  if (W_ready) w_state_nxt = S_WR_B;
      S_WR_B: begin
        if (W_ready) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_FIN;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_RD_Y;
          end
        end
      end
      S_FIN: begin
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs follow the state being entered so they are registered yet state-aligned
    case (w_state_nxt)
      S_RD_Y: begin
        w_busy_nxt  = 1'b1;
        w_ren_nxt   = 1'b1;
        w_raddr_nxt = ADDR_W'(Y_BASE) + ADDR_W'(w_idx_nxt);
      end
      S_RD_U: begin
        w_busy_nxt  = 1'b1;
        w_ren_nxt   = 1'b1;
        w_raddr_nxt = ADDR_W'(U_BASE) + ADDR_W'(w_idx_nxt);
      end
      S_RD_V: begin
        w_busy_nxt  = 1'b1;
        w_ren_nxt   = 1'b1;
        w_raddr_nxt = ADDR_W'(V_BASE) + ADDR_W'(w_idx_nxt);
      end
      S_LAT_V, S_CALC: w_busy_nxt = 1'b1;
      S_WR_R: begin
        w_busy_nxt  = 1'b1;
        w_wen_nxt   = 1'b1;
        w_waddr_nxt = ADDR_W'(R_BASE) + ADDR_W'(w_idx_nxt);
        w_wdata_nxt = (r_state == S_CALC) ? w_r_word : r_r_word;
      end
      S_WR_G: begin
        w_busy_nxt  = 1'b1;
        w_wen_nxt   = 1'b1;
        w_waddr_nxt = ADDR_W'(G_BASE) + ADDR_W'(w_idx_nxt);
        w_wdata_nxt = r_g_word;
      end
      S_WR_B: begin
        w_busy_nxt  = 1'b1;
        w_wen_nxt   = 1'b1;
        w_waddr_nxt = ADDR_W'(B_BASE) + ADDR_W'(w_idx_nxt);
        w_wdata_nxt = r_b_word;
      end
      S_FIN:   w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Index, sample capture, RGB results and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_y      <= '0;
      r_u      <= '0;
      r_v      <= '0;
      r_r_word <= '0;
      r_g_word <= '0;
      r_b_word <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_raddr  <= '0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ren   <= w_ren_nxt;
      r_wen   <= w_wen_nxt;
      r_raddr <= w_raddr_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      // Read data lands one cycle after its request
      if (r_state == S_RD_U)  r_y <= R_data;
      if (r_state == S_RD_V)  r_u <= R_data;
      if (r_state == S_LAT_V) r_v <= R_data;
      if (r_state == S_CALC) begin
        r_r_word <= w_r_word;
        r_g_word <= w_g_word;
        r_b_word <= w_b_word;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign R_en   = r_ren;
  assign R_addr = r_raddr;
  assign W_en   = r_wen;
  assign W_addr = r_waddr;
  assign W_data = r_wdata;

endmodule

// File: tb/tb_yuv2rgb_engine.sv
// Scoreboard bench for yuv2rgb_engine: memory model, reference colour maths, stall and reset scenarios.
module tb_yuv2rgb_engine;

  localparam int unsigned ADDR_W    = 20;
  localparam int unsigned NUM_WORDS = 2;
  localparam int unsigned Y_BASE    = 0;
  localparam int unsigned U_BASE    = 38400;
  localparam int unsigned V_BASE    = 76800;
  localparam int unsigned R_BASE    = 115200;
  localparam int unsigned G_BASE    = 153600;
  localparam int unsigned B_BASE    = 192000;
  localparam int          FRAME_CYC = 8 * NUM_WORDS + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst, start, busy, done, R_en, W_en, W_ready;
  logic [ADDR_W-1:0] R_addr, W_addr;
  logic [15:0]       R_data, W_data;

  logic [15:0] mem [int];
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  yuv2rgb_engine #(
    .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS),
    .Y_BASE(Y_BASE), .U_BASE(U_BASE), .V_BASE(V_BASE),
    .R_BASE(R_BASE), .G_BASE(G_BASE), .B_BASE(B_BASE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .R_en(R_en), .R_addr(R_addr), .R_data(R_data),
    .W_en(W_en), .W_ready(W_ready), .W_addr(W_addr), .W_data(W_data)
  );

  // Memory model: one-cycle read latency
  always @(posedge clk) begin
    if (rst) R_data <= 16'h0;
    else if (R_en) R_data <= mem.exists(int'(R_addr)) ? mem[int'(R_addr)] : 16'h0;
  end

  // Write scoreboard and read/write exclusivity
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      checks++;
      if (R_en && W_en) begin
        failures++;
        $display("FAIL rd_wr_overlap R_en=%0b W_en=%0b required not both", R_en, W_en);
      end
      if (W_en && W_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%h required no write", W_addr, W_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (W_addr !== mon_e.addr || W_data !== mon_e.data) begin
            failures++;
            $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                     W_addr, W_data, mon_e.addr, mon_e.data);
          end
        end
      end
    end
  end

  function automatic logic [7:0] clip(input int v);
    if (v < 0)   return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  // Reference pixel maths: returns {R, G, B}
  function automatic logic [23:0] conv(input logic [7:0] y, input logic [7:0] u,
                                       input logic [7:0] v);
    int c, d, e;
    d = int'(u) - 128;
    e = int'(v) - 128;
`ifdef YUV_FULL_RANGE_EN
    c = int'(y);
    return {clip((256*c + 359*e + 128) >>> 8),
            clip((256*c - 88*d - 183*e + 128) >>> 8),
            clip((256*c + 454*d + 128) >>> 8)};
`else
    c = int'(y) - 16;
    return {clip((298*c + 409*e + 128) >>> 8),
            clip((298*c - 100*d - 208*e + 128) >>> 8),
            clip((298*c + 516*d + 128) >>> 8)};
`endif
  endfunction

  function automatic logic [15:0] exp_word(input int ch, input logic [15:0] y,
                                           input logic [15:0] u, input logic [15:0] v);
    logic [23:0] pe, po;
    pe = conv(y[7:0],  u[7:0],  v[7:0]);
    po = conv(y[15:8], u[15:8], v[15:8]);
    case (ch)
      0:       return {po[23:16], pe[23:16]};
      1:       return {po[15:8],  pe[15:8]};
      default: return {po[7:0],   pe[7:0]};
    endcase
  endfunction

  // Place one word pair per index into memory and queue the expected R,G,B writes
  task automatic load_frame(input logic [15:0] y0, input logic [15:0] u0, input logic [15:0] v0,
                            input logic [15:0] y1, input logic [15:0] u1, input logic [15:0] v1);
    logic [15:0] ys[2], us[2], vs[2];
    ys[0] = y0; us[0] = u0; vs[0] = v0;
    ys[1] = y1; us[1] = u1; vs[1] = v1;
    for (int i = 0; i < 2; i++) begin
      mem[int'(Y_BASE) + i] = ys[i];
      mem[int'(U_BASE) + i] = us[i];
      mem[int'(V_BASE) + i] = vs[i];
      exp_q.push_back({ADDR_W'(R_BASE + i), exp_word(0, ys[i], us[i], vs[i])});
      exp_q.push_back({ADDR_W'(G_BASE + i), exp_word(1, ys[i], us[i], vs[i])});
      exp_q.push_back({ADDR_W'(B_BASE + i), exp_word(2, ys[i], us[i], vs[i])});
    end
  endtask

  // Pulse start and count cycles until done is seen (bounded)
  task automatic run_frame(output int cyc, output bit timed_out);
    start = 1'b1; cyc = 0; timed_out = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1; start = 1'b0; cyc++;
      if (done) begin timed_out = 1'b0; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; W_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, R_en, W_en} !== 4'b0 || R_addr !== '0 || W_addr !== '0 || W_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs busy=%0b done=%0b R_en=%0b W_en=%0b R_addr=%0d W_addr=%0d W_data=%h required all 0",
               busy, done, R_en, W_en, R_addr, W_addr, W_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_pixels();
    logic [15:0] vec [4][6];
    int cyc;
    bit to;
    vec[0] = '{16'h1010, 16'h8080, 16'h8080, 16'hEB10, 16'h8080, 16'h8080};
    vec[1] = '{16'h5151, 16'h5A5A, 16'hF0F0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vec[2] = '{16'h0000, 16'h8080, 16'h8080, 16'h00FF, 16'h00FF, 16'hFF00};
    for (int j = 0; j < 6; j++) vec[3][j] = 16'($urandom);
    for (int f = 0; f < 4; f++) begin
      load_frame(vec[f][0], vec[f][1], vec[f][2], vec[f][3], vec[f][4], vec[f][5]);
      run_frame(cyc, to);
      checks++;
      if (to || cyc != FRAME_CYC) begin
        failures++;
        $display("FAIL frame%0d_latency cycles=%0d timed_out=%0b required %0d", f, cyc, to, FRAME_CYC);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL frame%0d_idle done=%0b busy=%0b required 0 0", f, done, busy);
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL frame%0d_writes pending=%0d required 0", f, exp_q.size());
      end
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int cyc, d0;
    bit seen, fin;
    logic [ADDR_W-1:0] ha;
    logic [15:0] hd;
    load_frame(16'h3C80, 16'h40C0, 16'hA020, 16'h9911, 16'h22EE, 16'h7788);
    d0 = done_cnt; seen = 1'b0; fin = 1'b0; cyc = 0;
    start = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1; start = 1'b0; cyc++;
      if (!seen && W_en && W_addr == ADDR_W'(G_BASE)) begin
        seen = 1'b1; W_ready = 1'b0; ha = W_addr; hd = W_data;
        for (int s = 0; s < 5; s++) begin
          if (s == 2) start = 1'b1;
          @(posedge clk); #1; cyc++; start = 1'b0;
          checks++;
          if (W_en !== 1'b1 || W_addr !== ha || W_data !== hd) begin
            failures++;
            $display("FAIL stall_hold cycle=%0d W_en=%0b W_addr=%0d W_data=%h required 1 %0d %h",
                     s, W_en, W_addr, W_data, ha, hd);
          end
        end
        W_ready = 1'b1;
      end
      if (done) begin fin = 1'b1; break; end
    end
    checks++;
    if (!seen || !fin || cyc != FRAME_CYC + 5) begin
      failures++;
      $display("FAIL stall_latency cycles=%0d stalled=%0b done_seen=%0b required %0d 1 1",
               cyc, seen, fin, FRAME_CYC + 5);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || R_en !== 1'b0) begin
      failures++;
      $display("FAIL single_done done_pulses=%0d busy=%0b R_en=%0b required 1 0 0",
               done_cnt - d0, busy, R_en);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_writes pending=%0d required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_midframe_reset();
    int cyc, d0;
    bit seen, fin, act;
    load_frame(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1357, 16'h2468);
    seen = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1; start = 1'b0;
      if (R_en && R_addr == ADDR_W'(V_BASE + 1)) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL midrst_reach_rdv1 seen=0 required 1");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, R_en, W_en} !== 4'b0 || R_addr !== '0 || W_addr !== '0 || W_data !== 16'h0) begin
      failures++;
      $display("FAIL midrst_outputs busy=%0b done=%0b R_en=%0b W_en=%0b R_addr=%0d W_addr=%0d W_data=%h required all 0",
               busy, done, R_en, W_en, R_addr, W_addr, W_data);
    end
    checks++;
    if (exp_q.size() != 3) begin
      failures++;
      $display("FAIL midrst_pending pending=%0d required 3", exp_q.size());
    end
    exp_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    act = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (R_en || W_en || busy || done) act = 1'b1;
    end
    checks++;
    if (act || done_cnt != d0) begin
      failures++;
      $display("FAIL midrst_quiet activity=%0b done_pulses=%0d required 0 0", act, done_cnt - d0);
    end
    load_frame(16'hC0C0, 16'h3070, 16'h90B0, 16'h4020, 16'hE010, 16'h10E0);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (R_en !== 1'b1 || R_addr !== ADDR_W'(Y_BASE)) begin
      failures++;
      $display("FAIL restart_addr R_en=%0b R_addr=%0d required 1 %0d", R_en, R_addr, Y_BASE);
    end
    cyc = 1; fin = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin fin = 1'b1; break; end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (!fin || cyc != FRAME_CYC) begin
      failures++;
      $display("FAIL restart_latency cycles=%0d done_seen=%0b required %0d 1", cyc, fin, FRAME_CYC);
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL restart_writes pending=%0d required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; W_ready = 1'b1;
    test_reset();
    test_pixels();
    test_back_to_back();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
